// File: rtl/setup_stream_fifo.sv
// setup_stream_fifo: elastic buffer between frame_driver and the transform stage.
// Holds transform_setup_t beats in order, presents a registered first-word-fall-through
// head, keeps a per-frame triangle count and raises frame_drained when a fully fed
// frame has left the buffer.
// Optional build macro SETUP_FIFO_STATS_EN adds the sticky overflow flag and the
// per-frame high_water occupancy mark.

package setup_stream_fifo_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        logic      camera_transform_valid;
        logic      model_transform_valid;
        triangle_t triangle;
    } transform_setup_t;

    localparam int SETUP_W = $bits(transform_setup_t);
    // model_transform_valid sits directly above the triangle payload
    localparam int MODEL_BIT = $bits(triangle_t);

endpackage

module setup_stream_fifo
    import setup_stream_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CNT_W     = $clog2(DEPTH) + 1,
    parameter int TRI_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SETUP_W-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SETUP_W-1:0]   out_data,
    input  logic                 frame_feed_done,
    input  logic                 frame_start_render,
    output logic                 frame_drained,
    output logic [TRI_CNT_W-1:0] frame_tri_count,
    output logic [CNT_W-1:0]     occupancy
`ifdef SETUP_FIFO_STATS_EN
    ,
    output logic                 overflow,
    output logic [CNT_W-1:0]     high_water
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]     READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [TRI_CNT_W-1:0] TRI_ONE   = TRI_CNT_W'(1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("setup_stream_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [SETUP_W-1:0]   mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [SETUP_W-1:0]   out_data_q, out_data_d;
    logic [TRI_CNT_W-1:0] tri_cnt_q, tri_cnt_d;
    logic                 drained_q, drained_d;

    logic [CNT_W-1:0]     occ;
    logic [CNT_W-1:0]     occ_d;
    logic [CNT_W-1:0]     avail;
    logic                 push;
    logic                 pop;
    logic                 count_pop;

    // Occupancy includes the entry currently presented at the head.
    always_comb begin
        occ = wr_ptr_q - rd_ptr_q;
    end

    // Push/pop decisions, pointer update and head-stage refill.
    always_comb begin
        push     = in_valid && (occ != FULL_CNT);
        pop      = out_valid_q && out_ready;
        wr_ptr_d = wr_ptr_q + (push ? CNT_ONE : '0);
        rd_ptr_d = rd_ptr_q + (pop ? CNT_ONE : '0);
        occ_d    = wr_ptr_d - rd_ptr_d;
        // Entries written before this edge that remain after the pop; a beat
        // being written this edge is not yet readable.
        avail    = occ - (pop ? CNT_ONE : '0);

        // Headroom of two covers the beat already in flight from the producer.
        in_ready_d = (occ_d <= READY_MAX);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!out_valid_q || pop) begin
            if (avail != '0) begin
                out_valid_d = 1'b1;
                out_data_d  = mem[rd_ptr_d[AW-1:0]];
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Frame accounting: count model beats as they leave, report drained frames.
    always_comb begin
        count_pop = pop && out_data_q[MODEL_BIT];

        tri_cnt_d = tri_cnt_q;
        if (frame_start_render) begin
            // A beat popped on the frame boundary belongs to the new frame.
            tri_cnt_d = count_pop ? TRI_ONE : '0;
        end else if (count_pop && (tri_cnt_q != '1)) begin
            tri_cnt_d = tri_cnt_q + TRI_ONE;
        end

        drained_d = frame_feed_done && (occ == '0) && !out_valid_q
                    && !push && !frame_start_render;
    end

    // Storage array write port; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tri_cnt_q   <= '0;
            drained_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tri_cnt_q   <= tri_cnt_d;
            drained_q   <= drained_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign frame_drained   = drained_q;
    assign frame_tri_count = tri_cnt_q;
    assign occupancy       = occ;

`ifdef SETUP_FIFO_STATS_EN
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] high_water_q, high_water_d;

    // Sticky overflow and per-frame peak occupancy.
    always_comb begin
        overflow_d   = overflow_q || (in_valid && (occ == FULL_CNT));
        high_water_d = high_water_q;
        if (frame_start_render) begin
            high_water_d = occ;
        end else if (occ_d > high_water_q) begin
            high_water_d = occ_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            high_water_q <= high_water_d;
        end
    end

    assign overflow   = overflow_q;
    assign high_water = high_water_q;
`endif

endmodule
